// File: rtl/swap_ctrl_n_pkg.sv
// Shared constants for the register swap/copy sequencer.
// State encoding and request mode values.
package swap_ctrl_n_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam logic MODE_SWAP = 1'b0;
   localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/swap_ctrl_n_onehot_dec.sv
// Index-to-one-hot decoder with enable.
// Output is all zero when en is low.
module onehot_dec #(
   parameter int NREG  = 4,
   parameter int IDX_W = $clog2(NREG)
) (
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [NREG-1:0]  vec
);

   always_comb begin
      vec = '0;
      if (en) begin
         for (int i = 0; i < NREG; i++) begin
            vec[i] = (idx == IDX_W'(i));
         end
      end
   end

endmodule

// File: rtl/swap_ctrl_n.sv
// Bus sequencer: swaps two registers through a temp or copies one.
// Moore outputs decoded from state plus the captured request.
module swap_ctrl_n #(
   parameter int NREG  = 4,
   parameter int IDX_W = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [IDX_W-1:0] src,
   input  logic [IDX_W-1:0] dst,
   output logic [NREG-1:0]  drv,
   output logic [NREG-1:0]  ld,
   output logic             busy,
   output logic             done,
   output logic             err
);

   import swap_ctrl_n_pkg::*;

   localparam logic [IDX_W-1:0] TMP = IDX_W'(NREG - 1);

   state_t           state, nstate;
   logic             mode_q;
   logic [IDX_W-1:0] src_q, dst_q;
   logic             legal;
   logic             drv_en, ld_en;
   logic [IDX_W-1:0] drv_idx, ld_idx;

   // The temp register may never be named in a request.
   assign legal = (src != dst) && (src < TMP) && (dst < TMP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         mode_q <= MODE_SWAP;
         src_q  <= '0;
         dst_q  <= '0;
      end else begin
         state <= nstate;
         if (state == ST_IDLE && start && legal) begin
            mode_q <= mode;
            src_q  <= src;
            dst_q  <= dst;
         end
      end
   end

   always_comb begin
      nstate  = state;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      drv_en  = 1'b0;
      ld_en   = 1'b0;
      drv_idx = '0;
      ld_idx  = '0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               if (!legal)
                  nstate = ST_ERR;
               else if (mode == MODE_COPY)
                  nstate = ST_S3;
               else
                  nstate = ST_S1;
            end
         end
         ST_S1: begin
            busy    = 1'b1;
            drv_en  = 1'b1;
            drv_idx = src_q;
            ld_en   = 1'b1;
            ld_idx  = TMP;
            nstate  = ST_S2;
         end
         ST_S2: begin
            busy    = 1'b1;
            drv_en  = 1'b1;
            drv_idx = dst_q;
            ld_en   = 1'b1;
            ld_idx  = src_q;
            nstate  = ST_S3;
         end
         ST_S3: begin
            busy    = 1'b1;
            done    = 1'b1;
            drv_en  = 1'b1;
            drv_idx = (mode_q == MODE_SWAP) ? TMP : src_q;
            ld_en   = 1'b1;
            ld_idx  = dst_q;
            nstate  = ST_IDLE;
         end
         ST_ERR: begin
            busy   = 1'b1;
            err    = 1'b1;
            nstate = ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_drv (
      .en  (drv_en),
      .idx (drv_idx),
      .vec (drv)
   );

   onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_ld (
      .en  (ld_en),
      .idx (ld_idx),
      .vec (ld)
   );

endmodule

// File: tb/tb_swap_ctrl_n.sv
// Self-checking bench for swap_ctrl_n (NREG=4, temp=3).
// Expected outputs come from a transfer-list model of each request.
module tb_swap_ctrl_n;

   typedef struct packed {
      logic [3:0] drv;
      logic [3:0] ld;
      logic       busy;
      logic       done;
      logic       err;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       mode;
   logic [1:0] src;
   logic [1:0] dst;
   logic [3:0] drv;
   logic [3:0] ld;
   logic       busy;
   logic       done;
   logic       err;

   frame_t obs;
   frame_t ex;
   frame_t q[$];
   int     nchk  = 0;
   int     npass = 0;
   int     cyc   = 0;

   assign obs = '{drv: drv, ld: ld, busy: busy, done: done, err: err};

   always #5 clk = ~clk;

   swap_ctrl_n #(.NREG(4), .IDX_W(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .src   (src),
      .dst   (dst),
      .drv   (drv),
      .ld    (ld),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   function automatic logic [3:0] oh(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   // A request becomes the list of bus transfers it should perform.
   task automatic push_req(input logic m, input int s, input int d);
      int t;
      t = 3;
      if (s == d || s >= t || d >= t) begin
         q.push_back('{drv: 4'b0, ld: 4'b0, busy: 1, done: 0, err: 1});
      end else if (m) begin
         q.push_back('{drv: oh(s), ld: oh(d), busy: 1, done: 1, err: 0});
      end else begin
         q.push_back('{drv: oh(s), ld: oh(t), busy: 1, done: 0, err: 0});
         q.push_back('{drv: oh(d), ld: oh(s), busy: 1, done: 0, err: 0});
         q.push_back('{drv: oh(t), ld: oh(d), busy: 1, done: 1, err: 0});
      end
   endtask

   // Advance one clock and update the expected frame.
   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         q.delete();
         ex = '0;
      end else begin
         if (!ex.busy && start)
            push_req(mode, int'(src), int'(dst));
         if (q.size() > 0)
            ex = q.pop_front();
         else
            ex = '0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      mode = 1'b0;
      src = 2'd0;
      dst = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nchk++;
         if (obs !== frame_t'(0))
            $display("FAIL reset cyc%0d: got %b want %b", cyc, obs, 11'b0);
         else
            npass++;
      end
      start = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_swap();
      logic [3:0] wd[3];
      logic [3:0] wl[3];
      wd = '{4'b0001, 4'b0100, 4'b1000};
      wl = '{4'b1000, 4'b0001, 4'b0100};
      start = 1'b1;
      mode = 1'b0;
      src = 2'd0;
      dst = 2'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nchk++;
         if (drv !== wd[i] || ld !== wl[i] || done !== (i == 2)
             || busy !== 1'b1)
            $display("FAIL swap step%0d: got %b/%b d%b want %b/%b",
                     i, drv, ld, done, wd[i], wl[i]);
         else
            npass++;
         nchk++;
         if (obs !== ex)
            $display("FAIL swap_model step%0d: got %b want %b",
                     i, obs, ex);
         else
            npass++;
         tick();
      end
      nchk++;
      if (busy !== 1'b0 || obs !== ex)
         $display("FAIL swap_idle: got %b want %b", obs, ex);
      else
         npass++;
   endtask

   task automatic test_copy();
      start = 1'b1;
      mode = 1'b1;
      src = 2'd1;
      dst = 2'd0;
      tick();
      start = 1'b0;
      nchk++;
      if (drv !== 4'b0010 || ld !== 4'b0001 || done !== 1'b1
          || busy !== 1'b1 || obs !== ex)
         $display("FAIL copy: got %b want %b", obs, ex);
      else
         npass++;
      tick();
      nchk++;
      if (busy !== 1'b0 || obs !== ex)
         $display("FAIL copy_idle: got busy %b want 0", busy);
      else
         npass++;
   endtask

   task automatic test_errors();
      logic [1:0] es[3];
      logic [1:0] ed[3];
      es = '{2'd1, 2'd3, 2'd0};
      ed = '{2'd1, 2'd0, 2'd3};
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         mode = i[0];
         src = es[i];
         dst = ed[i];
         tick();
         start = 1'b0;
         nchk++;
         if (err !== 1'b1 || done !== 1'b0 || drv !== 4'b0
             || ld !== 4'b0 || obs !== ex)
            $display("FAIL err%0d: got %b want %b", i, obs, ex);
         else
            npass++;
         tick();
         nchk++;
         if (err !== 1'b0 || busy !== 1'b0)
            $display("FAIL err%0d_pulse: got err %b busy %b want 0 0",
                     i, err, busy);
         else
            npass++;
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      ndone = 0;
      start = 1'b1;
      mode = 1'b0;
      src = 2'd1;
      dst = 2'd2;
      tick();
      start = 1'b0;
      tick();
      nchk++;
      if (drv !== 4'b0100 || ld !== 4'b0010)
         $display("FAIL rmid_s2: got %b/%b want 0100/0010", drv, ld);
      else
         npass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nchk++;
      if (obs !== frame_t'(0) || obs !== ex)
         $display("FAIL rmid_clear: got %b want %b", obs, ex);
      else
         npass++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) ndone++;
      end
      nchk++;
      if (ndone != 0)
         $display("FAIL rmid_nodone: got %0d dones want 0", ndone);
      else
         npass++;
   endtask

   task automatic test_back_to_back();
      int last;
      int bad;
      int ndone;
      last = -1;
      bad = 0;
      ndone = 0;
      start = 1'b1;
      mode = 1'b0;
      src = 2'd0;
      dst = 2'd1;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (obs !== ex) bad++;
         if (last >= 0 && i == last + 1 && (busy || drv != 0))
            bad++;
         if (done) begin
            if (last >= 0 && i - last != 4) bad++;
            last = i;
            ndone++;
         end
      end
      start = 1'b0;
      tick();
      tick();
      nchk++;
      if (bad != 0 || ndone != 4)
         $display("FAIL b2b: got %0d bad, %0d dones want 0, 4",
                  bad, ndone);
      else
         npass++;
   endtask

   task automatic test_toggle();
      int bad;
      bad = 0;
      for (int r = 0; r < 6; r++) begin
         start = 1'b1;
         mode = r[0];
         src = 2'(r % 3);
         dst = 2'((r + 1) % 3);
         tick();
         for (int i = 0; i < 4; i++) begin
            if (obs !== ex) bad++;
            start = 1'($urandom);
            mode = 1'($urandom);
            src = 2'($urandom);
            dst = 2'($urandom);
            tick();
         end
         start = 1'b0;
         tick();
      end
      nchk++;
      if (bad != 0)
         $display("FAIL toggle: got %0d bad cycles want 0", bad);
      else
         npass++;
   endtask

   task automatic test_random();
      int bad;
      int ovl;
      bad = 0;
      ovl = 0;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         start = 1'($urandom);
         mode = 1'($urandom);
         src = 2'($urandom);
         dst = 2'($urandom);
         tick();
         if (obs !== ex) begin
            bad++;
            if (bad < 4)
               $display("FAIL rand cyc%0d: got %b want %b", cyc, obs, ex);
         end
         if ((drv & ld) != 4'b0) ovl++;
      end
      rst = 1'b0;
      start = 1'b0;
      nchk++;
      if (bad != 0)
         $display("FAIL rand_total: got %0d bad want 0", bad);
      else
         npass++;
      nchk++;
      if (ovl != 0)
         $display("FAIL drv_ld_overlap: got %0d want 0", ovl);
      else
         npass++;
   endtask

   initial begin
      ex = '0;
      test_reset();
      test_swap();
      test_copy();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_toggle();
      test_random();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
